// File: rtl/ram_browser_pkg.sv
// Shared types for the RAM browser: display modes and the supported read-latency ceiling.
package ram_browser_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    STEP   = 2'b01,
    AUTO   = 2'b10,
    HOLD   = 2'b11
  } mode_e;

  localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/ram_browser_if.sv
// Switch/button inputs, RAM read port and hex-display outputs of the RAM browser.
interface ram_browser_if
  import ram_browser_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  mode_e             mode;
  logic [ADDR_W-1:0] sw_addr;
  logic              step;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              wrap;
  logic [DATA_W-1:0] checksum;

  // master: switches, buttons and RAM; slave: the browser itself
  modport master (
    output mode, sw_addr, step, rd_data,
    input  rd_addr, disp_addr, disp_data, disp_valid, wrap, checksum
  );

  modport slave (
    input  mode, sw_addr, step, rd_data,
    output rd_addr, disp_addr, disp_data, disp_valid, wrap, checksum
  );

endinterface

// File: rtl/ram_browser_scan_tick.sv
// Auto-scan divider: counts 0..SCAN_DIV-1 while enabled and pulses tick on the last count.
module scan_tick #(
  parameter int SCAN_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // Neither enabled nor cleared means frozen, which is how HOLD keeps its place.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ram_browser.sv
// RAM browser: drives a RAM read port and presents an aligned address/data pair for display.
// Optional per-pass scan checksum is built when RAM_BROWSER_CHECKSUM_EN is defined.
module ram_browser
  import ram_browser_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 2,
  parameter int SCAN_DIV = 25_000_000
) (
  input  logic         clk,
  input  logic         reset,
  ram_browser_if.slave bus
);

  mode_e             mode_q;
  logic [ADDR_W-1:0] cur_addr, addr_d;
  logic              inc, wrap_d, wrap_q, tick;
  logic [ADDR_W-1:0] tag_q [RD_LAT];
  logic [RD_LAT-1:0] tag_vld_q;
  logic [ADDR_W-1:0] disp_addr_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              disp_tag_vld_q, disp_valid;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk   (clk),
    .reset (reset),
    .en    (bus.mode == AUTO),
    .clr   (bus.mode == MANUAL || bus.mode == STEP),
    .tick  (tick)
  );

  // The incoming mode governs this edge; a Step that arrives with a mode change is dropped.
  // NOTE: defaults first so every path assigns every output -- no latch is inferred.
  always_comb begin
    addr_d = cur_addr;
    inc    = 1'b0;
    case (bus.mode)
      MANUAL:  addr_d = bus.sw_addr;
      STEP:    inc = bus.step && (mode_q == STEP);
      AUTO:    inc = tick;
      default: ;
    endcase
    if (inc) addr_d = cur_addr + 1'b1;
    wrap_d = inc && (&cur_addr);
  end

  // tag_q[0] mirrors cur_addr; tag_q[RD_LAT-1] names the word currently on rd_data.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q         <= MANUAL;
      cur_addr       <= '0;
      wrap_q         <= 1'b0;
      // NOTE: the tag pipeline is reset (unlike a data RAM) because its valid bits gate disp_valid.
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      tag_vld_q      <= '0;
      disp_addr_q    <= '0;
      disp_data_q    <= '0;
      disp_tag_vld_q <= 1'b0;
    end else begin
      mode_q       <= bus.mode;
      cur_addr     <= addr_d;
      wrap_q       <= wrap_d;
      tag_q[0]     <= addr_d;
      tag_vld_q[0] <= 1'b1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i]     <= tag_q[i-1];
        tag_vld_q[i] <= tag_vld_q[i-1];
      end
      if (bus.mode != HOLD) begin
        disp_addr_q    <= tag_q[RD_LAT-1];
        disp_data_q    <= bus.rd_data;
        disp_tag_vld_q <= tag_vld_q[RD_LAT-1];
      end
    end
  end

  // Settled once the in-flight tags and the displayed tag all name cur_addr.
  always_comb begin
    disp_valid = disp_tag_vld_q && (&tag_vld_q) && (disp_addr_q == cur_addr);
    for (int i = 1; i < RD_LAT; i++) begin
      if (tag_q[i] != cur_addr) disp_valid = 1'b0;
    end
  end

  assign bus.rd_addr    = cur_addr;
  assign bus.disp_addr  = disp_addr_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid;
  assign bus.wrap       = wrap_q;

`ifdef RAM_BROWSER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_sum, checksum_q;
  logic              added_q, add_now;

  // Each address contributes once, on its first settled cycle; the wrap edge still counts the last one.
  always_comb begin
    add_now = (bus.mode == AUTO) && disp_valid && !added_q;
    acc_sum = acc_q + (add_now ? disp_data_q : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      added_q    <= 1'b0;
      checksum_q <= '0;
    end else if (bus.mode == AUTO) begin
      if (wrap_d) begin
        checksum_q <= acc_sum;
        acc_q      <= '0;
      end else begin
        acc_q      <= acc_sum;
      end
      added_q <= inc ? 1'b0 : (added_q | add_now);
    end else if (bus.mode != HOLD) begin
      acc_q   <= '0;
      added_q <= 1'b0;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule
